// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store sequencer with lane extract and read-modify-write (optional DMEM_CTRL_STATS_EN counters)
module dmem_ctrl #(
    parameter int DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [DMEM_ADDR_WIDTH+2:0] req_addr,
    input  logic [63:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [63:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]                mem_din,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic [63:0]                mem_dout
`ifdef DMEM_CTRL_STATS_EN
   ,output logic [31:0]                stat_loads,
    output logic [31:0]                stat_stores,
    output logic [31:0]                stat_errs
`endif
);
    localparam int BAW = DMEM_ADDR_WIDTH + 3;

    typedef enum logic [2:0] {IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [BAW-1:0]  addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            bad;
    logic [5:0]      shamt;
    logic [63:0]     size_mask, lane_mask, merged, sh, ld_val;
    logic            sgn;

    // Request legality: reserved funct3, unsigned stores, and natural-alignment violations
    always_comb begin
        bad = (req_funct3 == 3'b111) | (req_we & req_funct3[2]) |
              ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
              ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0])) |
              ((req_funct3[1:0] == 2'b11) & (|req_addr[2:0]));
    end

    // Lane datapath: store merge into the read entry and load extraction with extension
    always_comb begin
        shamt     = {addr_q[2:0], 3'b000};
        size_mask = (f3_q[1:0] == 2'b00) ? 64'h0000_0000_0000_00FF :
                    (f3_q[1:0] == 2'b01) ? 64'h0000_0000_0000_FFFF :
                    (f3_q[1:0] == 2'b10) ? 64'h0000_0000_FFFF_FFFF : '1;
        lane_mask = size_mask << shamt;
        merged    = (mem_dout & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
        sh        = mem_dout >> shamt;
        sgn       = ~f3_q[2];
        ld_val    = (f3_q[1:0] == 2'b00) ? {{56{sgn & sh[7]}}, sh[7:0]} :
                    (f3_q[1:0] == 2'b01) ? {{48{sgn & sh[15]}}, sh[15:0]} :
                    (f3_q[1:0] == 2'b10) ? {{32{sgn & sh[31]}}, sh[31:0]} : sh;
    end

    // Next-state logic: accept in IDLE, then walk the load, store or RMW sequence to RESP
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? RESP : !req_we ? LD_RD : (req_funct3[1:0] == 2'b11) ? ST_WR : RMW_RD;
            end
            LD_RD:   state_d = LD_DATA;
            LD_DATA: begin
                rdata_d = ld_val;
                state_d = RESP;
            end
            ST_WR:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q[BAW-1:3];
    assign mem_read  = (state_q == LD_RD) | (state_q == RMW_RD);
    assign mem_write = (state_q == ST_WR) | (state_q == RMW_WR);
    assign mem_din   = (state_q == RMW_WR) ? merged : (state_q == ST_WR) ? wdata_q : '0;

`ifdef DMEM_CTRL_STATS_EN
    logic [31:0] loads_q, stores_q, errs_q;

    // Per-op completion counters, bumped in the response cycle
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (state_q == RESP) begin
            errs_q   <= errs_q + {31'd0, err_q};
            stores_q <= stores_q + {31'd0, ~err_q & we_q};
            loads_q  <= loads_q + {31'd0, ~err_q & ~we_q};
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Load/store sequencer between the core's memory stage and the 64-bit-entry data memory (dmem). Accepts byte-addressed RISC-V loads/stores (B/H/W/D, signed/unsigned) over a valid/ready request and one-cycle response pulse. Performs lane extraction and sign/zero extension for loads. Performs read-modify-write for sub-doubleword stores; dmem supports only whole 64-bit, aligned entry writes. Flags misaligned or illegal requests without touching memory.

Parameters:
DMEM_ADDR_WIDTH, 10, dmem entry-index width (1024 x 64-bit = 8 KB); byte address width is DMEM_ADDR_WIDTH+3 (derived localparam)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_b  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept (high only in IDLE)
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 width/sign code
req_addr  input  DMEM_ADDR_WIDTH+3  byte address
req_wdata  input  64  store data, right-aligned
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  64  load result (0 for stores/errors)
rsp_err  output  1  valid with rsp_valid; misaligned/illegal
mem_addr  output  DMEM_ADDR_WIDTH  to dmem addr = latched req_addr[DMEM_ADDR_WIDTH+2:3]
mem_din  output  64  to dmem din
mem_read  output  1  to dmem mem_read
mem_write  output  1  to dmem mem_write
mem_dout  input  64  from dmem dout, valid the cycle after mem_read was high at an edge

Behaviour:
- Reset (async): state IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0; request regs cleared. mem_read/mem_write are decoded from state, so they drop immediately. A reset during an RMW before its write edge aborts the write; memory is unmodified.
- Accept: req_valid && req_ready at edge latches we/funct3/addr/wdata. No back-pressure on the response.
- funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU. 111 is illegal. Stores with funct3[2]=1 are illegal.
- Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0. Little-endian; byte lane = addr[2:0].
- States: IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP.
- IDLE + accept -> ERR path if illegal or misaligned: straight to RESP with rsp_err=1, rsp_rdata=0, no mem access.
- Load: IDLE -> LD_RD (mem_read=1) -> LD_DATA (capture mem_dout lanes, sign/zero extend into rsp_rdata) -> RESP.
- SD: IDLE -> ST_WR (mem_write=1, mem_din=wdata) -> RESP.
- SB/SH/SW: IDLE -> RMW_RD (mem_read=1) -> RMW_WR (mem_write=1). In RMW_WR, mem_din = mem_dout with the target lanes replaced by the low 8/16/32 bits of wdata -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Latency, accept edge to first rsp_valid cycle: load 3 cycles, SD 2 cycles, sub-word store 3 cycles, error 1 cycle. Back-to-back requests: next accept earliest in the cycle after RESP.
- mem_read and mem_write are never high simultaneously. Both are 0 in IDLE/RESP/LD_DATA. mem_addr holds the latched index throughout an op.
- mem_dout is ignored in every state except LD_DATA and RMW_WR; dmem returns 0 when not read.

Optional Feature:
DMEM_CTRL_STATS_EN
- Defined: adds outputs stat_loads, stat_stores, stat_errs (32-bit each). Each increments in its RESP cycle by op type (errors count only in stat_errs). They wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-RMW: SB to 0x010 with reset_b pulsed low during RMW_RD -> no mem_write edge; a later LD of 0x010 returns the prior value; rsp_valid stays 0 during reset.
- SD 0x1122334455667788 to 0x008, then LD 0x008 -> rsp_rdata 0x1122334455667788; store rsp 2 cycles, load rsp 3 cycles after accept.
- After the SD, SB 0xAB to 0x00B then LD 0x008 -> 0x11223344AB667788. LB 0x00B -> 0xFFFFFFFFFFFFFFAB; LBU 0x00B -> 0x00000000000000AB.
- SH 0x8001 to 0x00E then LH 0x00E -> 0xFFFFFFFFFFFF8001; LHU -> 0x8001. Lanes 0-5 of the entry are unchanged.
- LW to 0x002 (misaligned) -> rsp_err=1, rsp_rdata=0 one cycle after accept, mem_read never asserted. Store with funct3=100 -> rsp_err=1.
- Back-to-back load, store, load with req_valid held high -> req_ready low except in IDLE; three rsp_valid pulses, in order, each one cycle wide.
